// File: rtl/chess_pkg.sv
// Shared chess definitions for the board controller and the LCD renderer:
// piece numbering, the starting position and the move FSM encoding.
package chess_pkg;

    localparam int NUM_PIECES = 16;

    localparam int KING    = 0;
    localparam int QUEEN   = 1;
    localparam int BISHOP0 = 2;
    localparam int BISHOP1 = 3;
    localparam int KNIGHT0 = 4;
    localparam int KNIGHT1 = 5;
    localparam int ROOK0   = 6;
    localparam int ROOK1   = 7;
    localparam int PAWN0   = 8;

    // Paired pieces and pawns are laid out from the h-file inwards, e.g. pawn 8 starts on col 7.
    localparam logic [95:0] INIT_LVW = 96'h20928B30D38F0070460850C4;
    localparam logic [95:0] INIT_LVB = 96'hC31CB3D35DB7E3FE7EEBDEFC;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        SELECTED,
        COMMIT,
        HALT
    } state_t;

    function automatic logic [5:0] piece_loc(input logic [95:0] lv, input logic [3:0] idx);
        return lv[6*int'(idx) +: 6];
    endfunction

    // Stale locations of captured pieces are masked out by the alive vector.
    function automatic logic [15:0] match_live(input logic [95:0] lv,
                                               input logic [15:0] alive,
                                               input logic [5:0]  square);
        logic [15:0] hit;
        hit = '0;
        for (int k = 0; k < NUM_PIECES; k++) begin
            hit[k] = alive[k] && (lv[6*k +: 6] == square);
        end
        return hit;
    endfunction

endpackage

// File: rtl/btn_edge_sync.sv
// Synchronises an asynchronous button level and emits a registered
// one-cycle pulse on its rising edge.
module btn_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk12,
    input  logic reset,
    input  logic btn,
    output logic pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   last_level;

    always_ff @(posedge clk12) begin
        if (reset) begin
            sync_q     <= '0;
            last_level <= 1'b0;
            pulse      <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], btn};
            last_level <= sync_q[SYNC_STAGES-1];
            pulse      <= sync_q[SYNC_STAGES-1] & ~last_level;
        end
    end

endmodule

// File: rtl/board_state_ctrl.sv
// Owns the chess position: select on enter, destination on confirm, then an
// atomic commit that moves the piece, removes any captured opponent and flips the side.
module board_state_ctrl
    import chess_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk12,
    input  logic        reset,
    input  logic [5:0]  cursor,
    input  logic        enter_pressed,
    input  logic        confirm_pressed,
    input  logic        esc_pressed,
    input  logic [3:0]  pid,
    input  logic        found_piece,
    output logic [95:0] lvw,
    output logic [95:0] lvb,
    output logic [15:0] avw,
    output logic [15:0] avb,
    output logic        player,
    output logic        busy,
    output logic        move_done,
    output logic        move_rejected,
    output logic        captured,
    output logic        game_over
);

    logic ev_enter;
    logic ev_conf;
    logic ev_esc;

    btn_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_enter (
        .clk12(clk12),
        .reset(reset),
        .btn  (enter_pressed),
        .pulse(ev_enter)
    );

    btn_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_conf (
        .clk12(clk12),
        .reset(reset),
        .btn  (confirm_pressed),
        .pulse(ev_conf)
    );

    btn_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_esc (
        .clk12(clk12),
        .reset(reset),
        .btn  (esc_pressed),
        .pulse(ev_esc)
    );

    state_t      state;
    state_t      state_next;
    logic [5:0]  src;
    logic [5:0]  dst;
    logic [3:0]  sel;

    logic [95:0] own_lv;
    logic [15:0] own_av;
    logic [95:0] opp_lv;
    logic [15:0] opp_av;
    logic [15:0] own_hit;
    logic [15:0] opp_hit;
    logic        sel_ok;

    logic        latch_src;
    logic        load_dst;
    logic        reject;
    logic        do_commit;

    assign own_lv  = player ? lvb : lvw;
    assign own_av  = player ? avb : avw;
    assign opp_lv  = player ? lvw : lvb;
    assign opp_av  = player ? avw : avb;
    assign own_hit = match_live(own_lv, own_av, cursor);
    assign opp_hit = match_live(opp_lv, opp_av, dst);
    assign sel_ok  = found_piece && own_av[pid] && (piece_loc(own_lv, pid) == cursor);
    assign busy    = (state != IDLE);

    always_ff @(posedge clk12) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        latch_src  = 1'b0;
        load_dst   = 1'b0;
        reject     = 1'b0;
        do_commit  = 1'b0;
        case (state)
            IDLE: begin
                if (ev_enter) begin
                    state_next = LATCH;
                end
            end
            LATCH: begin
                latch_src = 1'b1;
                if (sel_ok) begin
                    state_next = SELECTED;
                end else begin
                    reject     = 1'b1;
                    state_next = IDLE;
                end
            end
            SELECTED: begin
                // Cancel wins over a simultaneous confirm.
                if (ev_esc) begin
                    state_next = IDLE;
                end else if (ev_conf) begin
                    load_dst = 1'b1;
                    if (cursor == src) begin
                        state_next = IDLE;
                    end else if (|own_hit) begin
                        reject = 1'b1;
                    end else begin
                        state_next = COMMIT;
                    end
                end
            end
            COMMIT: begin
                do_commit  = 1'b1;
                state_next = opp_hit[KING] ? HALT : IDLE;
            end
            HALT: begin
                state_next = HALT;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk12) begin
        if (reset) begin
            lvw           <= INIT_LVW;
            lvb           <= INIT_LVB;
            avw           <= 16'hFFFF;
            avb           <= 16'hFFFF;
            player        <= 1'b0;
            game_over     <= 1'b0;
            move_done     <= 1'b0;
            move_rejected <= 1'b0;
            captured      <= 1'b0;
            src           <= '0;
            dst           <= '0;
            sel           <= '0;
        end else begin
            move_done     <= do_commit;
            captured      <= do_commit & (|opp_hit);
            move_rejected <= reject;
            if (latch_src) begin
                src <= cursor;
                sel <= pid;
            end
            if (load_dst) begin
                dst <= cursor;
            end
            // Move, capture and turn change land on the same edge.
            if (do_commit) begin
                if (player) begin
                    lvb[6*int'(sel) +: 6] <= dst;
                    avw                   <= avw & ~opp_hit;
                end else begin
                    lvw[6*int'(sel) +: 6] <= dst;
                    avb                   <= avb & ~opp_hit;
                end
                player <= ~player;
                if (opp_hit[KING]) begin
                    game_over <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_board_state_ctrl.sv
// Scoreboard bench for board_state_ctrl: directed moves push expected results,
// a monitor pops and compares whenever move_done or move_rejected pulses.
module tb_board_state_ctrl;

    localparam int SYNC_STAGES = 2;
    localparam logic [95:0] INIT_LVW = 96'h20928B30D38F0070460850C4;
    localparam logic [95:0] INIT_LVB = 96'hC31CB3D35DB7E3FE7EEBDEFC;

    logic        clk12 = 1'b0;
    logic        reset;
    logic [5:0]  cursor;
    logic        enter_pressed;
    logic        confirm_pressed;
    logic        esc_pressed;
    logic [3:0]  pid;
    logic        found_piece;
    logic [95:0] lvw;
    logic [95:0] lvb;
    logic [15:0] avw;
    logic [15:0] avb;
    logic        player;
    logic        busy;
    logic        move_done;
    logic        move_rejected;
    logic        captured;
    logic        game_over;

    board_state_ctrl #(.SYNC_STAGES(SYNC_STAGES)) dut (
        .clk12          (clk12),
        .reset          (reset),
        .cursor         (cursor),
        .enter_pressed  (enter_pressed),
        .confirm_pressed(confirm_pressed),
        .esc_pressed    (esc_pressed),
        .pid            (pid),
        .found_piece    (found_piece),
        .lvw            (lvw),
        .lvb            (lvb),
        .avw            (avw),
        .avb            (avb),
        .player         (player),
        .busy           (busy),
        .move_done      (move_done),
        .move_rejected  (move_rejected),
        .captured       (captured),
        .game_over      (game_over)
    );

    always #5 clk12 = ~clk12;

    typedef struct {
        logic        rejected;
        logic        cap;
        logic        ply;
        logic        gover;
        logic [95:0] lw;
        logic [95:0] lb;
        logic [15:0] aw;
        logic [15:0] ab;
    } exp_t;

    exp_t        exp_q[$];
    logic [95:0] m_lvw;
    logic [95:0] m_lvb;
    logic [15:0] m_avw;
    logic [15:0] m_avb;
    logic        m_ply;
    logic        m_gover;
    int          n_pass  = 0;
    int          n_total = 0;

    task automatic check_output(input string name, input logic [95:0] actual, input logic [95:0] expected);
        n_total++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic expect_event(input logic rejected, input logic cap);
        exp_t e;
        e.rejected = rejected;
        e.cap      = cap;
        e.ply      = m_ply;
        e.gover    = m_gover;
        e.lw       = m_lvw;
        e.lb       = m_lvb;
        e.aw       = m_avw;
        e.ab       = m_avb;
        exp_q.push_back(e);
    endtask

    // Any pulse with nothing queued is itself a failure.
    always @(negedge clk12) begin
        if (reset === 1'b0 && (move_done === 1'b1 || move_rejected === 1'b1)) begin
            if (exp_q.size() == 0) begin
                check_output("unexpected_event", {94'b0, move_done, move_rejected}, 96'b0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check_output("event_kind", {move_done, move_rejected}, {~e.rejected, e.rejected});
                check_output("ev_captured", captured, e.cap);
                check_output("ev_player", player, e.ply);
                check_output("ev_game_over", game_over, e.gover);
                check_output("ev_lvw", lvw, e.lw);
                check_output("ev_lvb", lvb, e.lb);
                check_output("ev_avw", avw, e.aw);
                check_output("ev_avb", avb, e.ab);
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk12);
    endtask

    task automatic model_reset();
        m_lvw   = INIT_LVW;
        m_lvb   = INIT_LVB;
        m_avw   = 16'hFFFF;
        m_avb   = 16'hFFFF;
        m_ply   = 1'b0;
        m_gover = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk12);
        reset = 1'b1;
        model_reset();
        wait_cycles(2);
        reset = 1'b0;
        wait_cycles(1);
    endtask

    task automatic press(input logic e, input logic c, input logic x);
        @(negedge clk12);
        enter_pressed   = e;
        confirm_pressed = c;
        esc_pressed     = x;
        wait_cycles(SYNC_STAGES + 4);
        enter_pressed   = 1'b0;
        confirm_pressed = 1'b0;
        esc_pressed     = 1'b0;
        wait_cycles(SYNC_STAGES + 3);
    endtask

    task automatic apply_stimulus(input logic [5:0] cur, input logic [3:0] p, input logic f);
        cursor      = cur;
        pid         = p;
        found_piece = f;
        press(1'b1, 1'b0, 1'b0);
    endtask

    task automatic confirm_to(input logic [5:0] cur);
        cursor = cur;
        press(1'b0, 1'b1, 1'b0);
    endtask

    task automatic check_initial(input string tag);
        check_output({tag, "_lvw"}, lvw, INIT_LVW);
        check_output({tag, "_lvb"}, lvb, INIT_LVB);
        check_output({tag, "_avw"}, avw, 16'hFFFF);
        check_output({tag, "_avb"}, avb, 16'hFFFF);
        check_output({tag, "_player"}, player, 1'b0);
        check_output({tag, "_busy"}, busy, 1'b0);
        check_output({tag, "_game_over"}, game_over, 1'b0);
    endtask

    initial begin
        int lat;
        reset           = 1'b1;
        cursor          = '0;
        pid             = '0;
        found_piece     = 1'b0;
        enter_pressed   = 1'b0;
        confirm_pressed = 1'b0;
        esc_pressed     = 1'b0;
        model_reset();
        wait_cycles(3);
        reset = 1'b0;
        wait_cycles(1);
        check_initial("reset");
        check_output("reset_pulses", {move_done, move_rejected, captured}, 3'b000);

        // Black pawn (index 11 on e7) offered while white is to move.
        expect_event(1'b1, 1'b0);
        apply_stimulus(6'o64, 4'd11, 1'b1);
        check_output("wrong_side_busy", busy, 1'b0);
        check_output("wrong_side_queue", exp_q.size(), 0);

        // e2-e4 with confirm-to-done latency measured from the button edge.
        apply_stimulus(6'o14, 4'd11, 1'b1);
        check_output("e2_selected_busy", busy, 1'b1);
        m_lvw[71:66] = 6'o34;
        m_ply        = 1'b1;
        expect_event(1'b0, 1'b0);
        cursor = 6'o34;
        @(negedge clk12);
        confirm_pressed = 1'b1;
        lat = 0;
        while (move_done !== 1'b1 && lat < 20) begin
            @(negedge clk12);
            lat++;
        end
        check_output("conf_latency", lat, SYNC_STAGES + 3);
        confirm_pressed = 1'b0;
        wait_cycles(SYNC_STAGES + 3);
        check_output("e4_loc", lvw[71:66], 6'o34);
        check_output("e4_queue", exp_q.size(), 0);

        // Capture: white d-pawn to d3, black e-pawn to e4, white takes on e4.
        do_reset();
        apply_stimulus(6'o13, 4'd12, 1'b1);
        m_lvw[77:72] = 6'o23;
        m_ply        = 1'b1;
        expect_event(1'b0, 1'b0);
        confirm_to(6'o23);
        apply_stimulus(6'o64, 4'd11, 1'b1);
        m_lvb[71:66] = 6'o34;
        m_ply        = 1'b0;
        expect_event(1'b0, 1'b0);
        confirm_to(6'o34);
        apply_stimulus(6'o23, 4'd12, 1'b1);
        m_lvw[77:72] = 6'o34;
        m_avb[11]    = 1'b0;
        m_ply        = 1'b1;
        expect_event(1'b0, 1'b1);
        confirm_to(6'o34);
        check_output("capture_avb", avb, 16'hF7FF);
        check_output("capture_queue", exp_q.size(), 0);

        // Captured piece cannot be selected; nor can an empty square.
        expect_event(1'b1, 1'b0);
        apply_stimulus(6'o34, 4'd11, 1'b1);
        expect_event(1'b1, 1'b0);
        apply_stimulus(6'o60, 4'd15, 1'b0);

        apply_stimulus(6'o60, 4'd15, 1'b1);
        m_lvb[95:90] = 6'o50;
        m_ply        = 1'b0;
        expect_event(1'b0, 1'b0);
        confirm_to(6'o50);

        // White rook onto its own knight: rejected, stays selected, esc leaves.
        apply_stimulus(6'o00, 4'd7, 1'b1);
        expect_event(1'b1, 1'b0);
        confirm_to(6'o01);
        check_output("own_occ_busy", busy, 1'b1);
        press(1'b0, 1'b0, 1'b1);
        check_output("own_occ_esc_busy", busy, 1'b0);
        check_output("own_occ_lvw", lvw, m_lvw);
        check_output("own_occ_queue", exp_q.size(), 0);

        // Confirming the source square deselects silently.
        apply_stimulus(6'o11, 4'd14, 1'b1);
        check_output("deselect_busy_before", busy, 1'b1);
        confirm_to(6'o11);
        check_output("deselect_busy_after", busy, 1'b0);
        check_output("deselect_player", player, 1'b0);

        // Esc and confirm together.
        apply_stimulus(6'o10, 4'd15, 1'b1);
        cursor = 6'o20;
        press(1'b0, 1'b1, 1'b1);
        check_output("esc_conf_busy", busy, 1'b0);
        check_output("esc_conf_lvw", lvw, m_lvw);
        check_output("esc_conf_player", player, 1'b0);

        // Queen takes the black king.
        apply_stimulus(6'o03, 4'd1, 1'b1);
        m_lvw[11:6] = 6'o74;
        m_avb[0]    = 1'b0;
        m_ply       = 1'b1;
        m_gover     = 1'b1;
        expect_event(1'b0, 1'b1);
        confirm_to(6'o74);
        check_output("king_game_over", game_over, 1'b1);
        check_output("king_halt_busy", busy, 1'b1);
        apply_stimulus(6'o61, 4'd14, 1'b1);
        confirm_to(6'o51);
        check_output("halt_player", player, 1'b1);
        check_output("halt_lvb", lvb, m_lvb);
        check_output("halt_busy", busy, 1'b1);
        check_output("halt_queue", exp_q.size(), 0);

        // Reset while a piece is selected.
        do_reset();
        apply_stimulus(6'o14, 4'd11, 1'b1);
        check_output("mid_sel_busy", busy, 1'b1);
        do_reset();
        check_initial("mid_reset");

        check_output("final_queue", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
